// File: rtl/ascii_entry_pkg.sv
// Shared constants and encodings for the ASCII hex-entry block.
package ascii_entry_pkg;

    // Control characters recognised by the entry logic
    localparam logic [7:0] ASC_BS  = 8'h08;
    localparam logic [7:0] ASC_CR  = 8'h0D;
    localparam logic [7:0] ASC_ESC = 8'h1B;

    // Edit-buffer occupancy: empty, partially filled, full
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ENTRY = 2'd1,
        ST_FULL  = 2'd2
    } entry_state_e;

    // Meaning of an incoming byte
    typedef enum logic [2:0] {
        KC_NONE = 3'd0,
        KC_HEX  = 3'd1,
        KC_BS   = 3'd2,
        KC_ENT  = 3'd3,
        KC_ESC  = 3'd4
    } key_class_e;

    // Low nibble of a letter 'a'-'f' / 'A'-'F' is 1..6; add 9 for 10..15
    function automatic logic [3:0] letter_nibble(input logic [7:0] c);
        return c[3:0] + 4'd9;
    endfunction

endpackage

// File: rtl/ascii_hex_classify.sv
// Combinational decoder: ASCII byte -> key class plus hex nibble value.
module ascii_hex_classify
    import ascii_entry_pkg::*;
(
    input  logic [7:0]  ascii_data,
    output key_class_e  key_class,
    output logic [3:0]  nibble
);

    // Range checks for hex digits first, then the three control characters
    always_comb begin
        key_class = KC_NONE;
        nibble    = 4'h0;
        if (ascii_data >= 8'h30 && ascii_data <= 8'h39) begin
            key_class = KC_HEX;
            nibble    = ascii_data[3:0];
        end else if ((ascii_data >= 8'h61 && ascii_data <= 8'h66) ||
                     (ascii_data >= 8'h41 && ascii_data <= 8'h46)) begin
            key_class = KC_HEX;
            nibble    = letter_nibble(ascii_data);
        end else begin
            case (ascii_data)
                ASC_BS:  key_class = KC_BS;
                ASC_CR:  key_class = KC_ENT;
                ASC_ESC: key_class = KC_ESC;
                default: key_class = KC_NONE;
            endcase
        end
    end

endmodule

// File: rtl/ascii_hex_entry.sv
// Hex number entry from an ASCII key stream, with backspace / escape / enter.
// Optional repeat filter enabled by defining ASCII_ENTRY_REPEAT_FILTER_EN.
module ascii_hex_entry
    import ascii_entry_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned HOLDOFF_CYCLES = 5000000,
    localparam int unsigned W             = 4 * DIGITS,
    localparam int unsigned CW            = $clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    ascii_data,
    input  logic          ascii_data_stb,
    output logic [W-1:0]  disp_num,
    output logic [CW-1:0] digit_count,
    output logic [W-1:0]  committed_num,
    output logic          commit_stb,
    output logic          err_stb
);

    if (DIGITS < 1) begin : g_bad_digits
        $error("DIGITS must be >= 1");
    end
    if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
        $error("HOLDOFF_CYCLES must be >= 1");
    end

    key_class_e   key_class;
    logic [3:0]   nibble;
    logic         key_pass;
    logic         key_stb;

    entry_state_e state_q, state_d;
    logic [W-1:0] edit_q, edit_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0] committed_q, committed_d;
    logic         commit_stb_q, commit_stb_d;
    logic         err_stb_q, err_stb_d;

    ascii_hex_classify u_classify (
        .ascii_data (ascii_data),
        .key_class  (key_class),
        .nibble     (nibble)
    );

`ifdef ASCII_ENTRY_REPEAT_FILTER_EN
    localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 1);

    logic [7:0]    last_byte_q, last_byte_d;
    logic [HW-1:0] hold_q, hold_d;

    // hold_q counts edges since the last accepted strobe (1 on the edge after it)
    assign key_pass = (ascii_data != last_byte_q) || (hold_q >= HW'(HOLDOFF_CYCLES));

    // Repeat-filter next state: reload on accept, otherwise saturating count
    always_comb begin
        last_byte_d = last_byte_q;
        hold_d      = hold_q;
        if (ascii_data_stb && key_pass) begin
            last_byte_d = ascii_data;
            hold_d      = HW'(1);
        end else if (hold_q < HW'(HOLDOFF_CYCLES)) begin
            hold_d = hold_q + HW'(1);
        end
    end

    // Repeat-filter registers; reset leaves the window already expired
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_byte_q <= 8'h00;
            hold_q      <= HW'(HOLDOFF_CYCLES);
        end else begin
            last_byte_q <= last_byte_d;
            hold_q      <= hold_d;
        end
    end
`else
    assign key_pass = 1'b1;
`endif

    assign key_stb = ascii_data_stb && key_pass;

    // Entry FSM next state, buffer edits and pulse generation
    always_comb begin
        state_d      = state_q;
        edit_d       = edit_q;
        count_d      = count_q;
        committed_d  = committed_q;
        commit_stb_d = 1'b0;
        err_stb_d    = 1'b0;
        if (key_stb) begin
            unique case (key_class)
                KC_HEX: begin
                    if (state_q == ST_FULL) begin
                        err_stb_d = 1'b1;
                    end else begin
                        edit_d  = (edit_q << 4) | W'(nibble);
                        count_d = count_q + CW'(1);
                        state_d = (count_q == CW'(DIGITS - 1)) ? ST_FULL : ST_ENTRY;
                    end
                end
                KC_BS: begin
                    if (state_q == ST_EMPTY) begin
                        err_stb_d = 1'b1;
                    end else begin
                        edit_d  = edit_q >> 4;
                        count_d = count_q - CW'(1);
                        state_d = (count_q == CW'(1)) ? ST_EMPTY : ST_ENTRY;
                    end
                end
                KC_ENT: begin
                    committed_d  = edit_q;
                    commit_stb_d = 1'b1;
                    edit_d       = '0;
                    count_d      = '0;
                    state_d      = ST_EMPTY;
                end
                KC_ESC: begin
                    edit_d  = '0;
                    count_d = '0;
                    state_d = ST_EMPTY;
                end
                default: ;
            endcase
        end
    end

    // Entry state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            edit_q       <= '0;
            count_q      <= '0;
            committed_q  <= '0;
            commit_stb_q <= 1'b0;
            err_stb_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edit_q       <= edit_d;
            count_q      <= count_d;
            committed_q  <= committed_d;
            commit_stb_q <= commit_stb_d;
            err_stb_q    <= err_stb_d;
        end
    end

    assign disp_num      = edit_q;
    assign digit_count   = count_q;
    assign committed_num = committed_q;
    assign commit_stb    = commit_stb_q;
    assign err_stb       = err_stb_q;

endmodule
